// File: rtl/tt_opacc_pkg.sv
// -----------------------------------------------------------------------------
// tt_opacc_pkg
// Shared types for the outer-product accumulator (tt_opacc) and its command
// sequencer (tt_opacc_seq).
//   - OPACC_* constants : default geometry; the packed command struct is sized
//                         from these, so sequencer parameters must match them.
//   - opacc_op_e        : matrix-register command opcode (ACC/WR/RD/CLR).
//   - opacc_seq_state_e : sequencer FSM state.
//   - opacc_cmd_t       : one accepted command {op, mreg, row, a, b}.
// -----------------------------------------------------------------------------
package tt_opacc_pkg;

  localparam int unsigned OPACC_VL        = 4;   // elements per row
  localparam int unsigned OPACC_ML        = 4;   // rows per matrix register
  localparam int unsigned OPACC_NUM_MREGS = 2;
  localparam int unsigned OPACC_XLEN      = 64;
  localparam int unsigned OPACC_MREG_AW   = $clog2(OPACC_NUM_MREGS);
  localparam int unsigned OPACC_ROW_AW    = $clog2(OPACC_ML);

  typedef enum logic [1:0] {
    OP_ACC = 2'd0,
    OP_WR  = 2'd1,
    OP_RD  = 2'd2,
    OP_CLR = 2'd3
  } opacc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CLR  = 2'd2,
    ST_RSP  = 2'd3
  } opacc_seq_state_e;

  typedef struct packed {
    opacc_op_e                          op;
    logic [OPACC_MREG_AW-1:0]           mreg;
    logic [OPACC_ROW_AW-1:0]            row;
    logic [OPACC_ML*OPACC_XLEN-1:0]     a;
    logic [OPACC_VL*OPACC_XLEN-1:0]     b;
  } opacc_cmd_t;

endpackage

// File: rtl/tt_opacc_seq.sv
// -----------------------------------------------------------------------------
// tt_opacc_seq
// Command sequencer in front of the tt_opacc datapath. Takes ACC/WR/RD/CLR
// commands over valid/ready, turns each into registered datapath strobes,
// addresses and operands, and returns RD row data over a registered
// valid/ready response port.
//
// Ports (AW = MREG_ADDR_WIDTH + ROW_ADDR_WIDTH):
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_op/mreg/row/a/b     command fields
//   o_vab_valid               outer-product accumulate strobe (ACC)
//   o_c_valid                 row-write strobe (WR, CLR)
//   o_wraddr / o_rdaddr       datapath {mreg,row} write / read address
//   o_a, o_b, o_c             datapath A / B operands, row-write data
//   i_dp_c                    datapath read data, combinational from o_rdaddr
//   o_rsp_valid/i_rsp_ready   RD response handshake, o_rsp_data the row
//   o_idle                    nothing in flight
//
// Geometry parameters must match the tt_opacc_pkg constants, since the
// latched command uses the package struct.
// -----------------------------------------------------------------------------
module tt_opacc_seq
  import tt_opacc_pkg::*;
#(
  parameter int unsigned vl              = OPACC_VL,
  parameter int unsigned ml              = OPACC_ML,
  parameter int unsigned NUM_MREGS       = OPACC_NUM_MREGS,
  parameter int unsigned MREG_ADDR_WIDTH = $clog2(NUM_MREGS),
  parameter int unsigned ROW_ADDR_WIDTH  = $clog2(ml),
  parameter int unsigned XLEN            = OPACC_XLEN
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset_n,
  input  logic                                       i_cmd_valid,
  output logic                                       o_cmd_ready,
  input  opacc_op_e                                  i_cmd_op,
  input  logic [MREG_ADDR_WIDTH-1:0]                 i_cmd_mreg,
  input  logic [ROW_ADDR_WIDTH-1:0]                  i_cmd_row,
  input  logic [ml*XLEN-1:0]                         i_cmd_a,
  input  logic [vl*XLEN-1:0]                         i_cmd_b,
  output logic                                       o_vab_valid,
  output logic                                       o_c_valid,
  output logic [MREG_ADDR_WIDTH+ROW_ADDR_WIDTH-1:0]  o_wraddr,
  output logic [MREG_ADDR_WIDTH+ROW_ADDR_WIDTH-1:0]  o_rdaddr,
  output logic [ml*XLEN-1:0]                         o_a,
  output logic [vl*XLEN-1:0]                         o_b,
  output logic [vl*XLEN-1:0]                         o_c,
  input  logic [vl*XLEN-1:0]                         i_dp_c,
  output logic                                       o_rsp_valid,
  input  logic                                       i_rsp_ready,
  output logic [vl*XLEN-1:0]                         o_rsp_data,
  output logic                                       o_idle
);

  localparam int unsigned AW = MREG_ADDR_WIDTH + ROW_ADDR_WIDTH;

  opacc_seq_state_e            state_q, state_d;
  opacc_cmd_t                  cmd_q, cmd_d;
  logic [ROW_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                        vab_valid_q, vab_valid_d;
  logic                        c_valid_q, c_valid_d;
  logic [AW-1:0]               wraddr_q, wraddr_d;
  logic [AW-1:0]               rdaddr_q, rdaddr_d;
  logic [vl*XLEN-1:0]          c_q, c_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [vl*XLEN-1:0]          rsp_data_q, rsp_data_d;

  opacc_cmd_t                  cmd_in;
  logic                        exec_accwr;
  logic                        cmd_fire;
  logic [ROW_ADDR_WIDTH-1:0]   cnt_next;

  assign cmd_in = '{op: i_cmd_op, mreg: i_cmd_mreg, row: i_cmd_row, a: i_cmd_a, b: i_cmd_b};

  // ACC/WR finish in their single EXEC cycle, so a new command may be taken
  // while they are strobing. Any opcode is safe here: the datapath commits the
  // ACC/WR on the very edge that accepts the follower, so a following RD reads
  // the updated row and a following CLR overwrites it.
  assign exec_accwr  = (state_q == ST_EXEC) && ((cmd_q.op == OP_ACC) || (cmd_q.op == OP_WR));
  assign o_cmd_ready = i_reset_n && ((state_q == ST_IDLE) || exec_accwr);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign cnt_next    = cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    vab_valid_d = 1'b0;
    c_valid_d   = 1'b0;
    wraddr_d    = wraddr_q;
    rdaddr_d    = rdaddr_q;
    c_d         = c_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE, ST_EXEC: begin
        if ((state_q == ST_EXEC) && (cmd_q.op == OP_RD)) begin
          // Read address has been on o_rdaddr all cycle; capture the row.
          rsp_data_d  = i_dp_c;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (cmd_fire) begin
          cmd_d = cmd_in;
          case (i_cmd_op)
            OP_ACC: begin
              vab_valid_d = 1'b1;
              wraddr_d    = {i_cmd_mreg, {ROW_ADDR_WIDTH{1'b0}}};
              state_d     = ST_EXEC;
            end
            OP_WR: begin
              c_valid_d = 1'b1;
              wraddr_d  = {i_cmd_mreg, i_cmd_row};
              c_d       = i_cmd_b;
              state_d   = ST_EXEC;
            end
            OP_RD: begin
              rdaddr_d = {i_cmd_mreg, i_cmd_row};
              state_d  = ST_EXEC;
            end
            default: begin  // OP_CLR: first zero-row strobe goes out next cycle
              c_valid_d = 1'b1;
              wraddr_d  = {i_cmd_mreg, {ROW_ADDR_WIDTH{1'b0}}};
              c_d       = '0;
              cnt_d     = '0;
              state_d   = ST_CLR;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLR: begin
        // cnt_q is the row whose zero-write strobe is on the outputs now.
        if (cnt_q == ROW_ADDR_WIDTH'(ml - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d     = cnt_next;
          c_valid_d = 1'b1;
          wraddr_d  = {cmd_q.mreg, cnt_next};
          c_d       = '0;
        end
      end

      ST_RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      // NOTE: the wide operand/data registers are reset too, because the
      // outputs they drive must read zero out of reset; these are ordinary
      // registers, not a storage array, so the reset cost is acceptable.
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      vab_valid_q <= 1'b0;
      c_valid_q   <= 1'b0;
      wraddr_q    <= '0;
      rdaddr_q    <= '0;
      c_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      vab_valid_q <= vab_valid_d;
      c_valid_q   <= c_valid_d;
      wraddr_q    <= wraddr_d;
      rdaddr_q    <= rdaddr_d;
      c_q         <= c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_vab_valid = vab_valid_q;
  assign o_c_valid   = c_valid_q;
  assign o_wraddr    = wraddr_q;
  assign o_rdaddr    = rdaddr_q;
  assign o_a         = cmd_q.a;
  assign o_b         = cmd_q.b;
  assign o_c         = c_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_idle      = (state_q == ST_IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_tt_opacc_seq.sv
// -----------------------------------------------------------------------------
// tb_tt_opacc_seq
// Drives tt_opacc_seq with directed and random commands. A simple stand-in for
// the tt_opacc datapath reacts to the sequencer's strobes; a transaction-level
// model predicts matrix contents, handshake availability and per-cycle
// outputs, and one compare process checks the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_tt_opacc_seq;
  import tt_opacc_pkg::*;

  localparam int VL  = 4;
  localparam int ML  = 4;
  localparam int NM  = 2;
  localparam int XL  = 64;
  localparam int MAW = 1;
  localparam int RAW = 2;
  localparam int AW  = MAW + RAW;
  localparam int DW  = VL * XL;

  logic            clk;
  logic            i_reset_n;
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  opacc_op_e       i_cmd_op;
  logic [MAW-1:0]  i_cmd_mreg;
  logic [RAW-1:0]  i_cmd_row;
  logic [ML*XL-1:0] i_cmd_a;
  logic [DW-1:0]   i_cmd_b;
  logic            o_vab_valid;
  logic            o_c_valid;
  logic [AW-1:0]   o_wraddr;
  logic [AW-1:0]   o_rdaddr;
  logic [ML*XL-1:0] o_a;
  logic [DW-1:0]   o_b;
  logic [DW-1:0]   o_c;
  logic [DW-1:0]   i_dp_c;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [DW-1:0]   o_rsp_data;
  logic            o_idle;

  tt_opacc_seq #(
    .vl(VL), .ml(ML), .NUM_MREGS(NM), .MREG_ADDR_WIDTH(MAW),
    .ROW_ADDR_WIDTH(RAW), .XLEN(XL)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_mreg(i_cmd_mreg), .i_cmd_row(i_cmd_row),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_vab_valid(o_vab_valid), .o_c_valid(o_c_valid),
    .o_wraddr(o_wraddr), .o_rdaddr(o_rdaddr),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .i_dp_c(i_dp_c),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_idle(o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- datapath stand-in (tt_opacc behaviour) ----------------
  logic [XL-1:0] dp_mem [NM][ML][VL];

  always @(posedge clk) begin
    if (!i_reset_n) begin
      for (int m = 0; m < NM; m++)
        for (int r = 0; r < ML; r++)
          for (int j = 0; j < VL; j++) dp_mem[m][r][j] <= '0;
    end else begin
      if (o_vab_valid)
        for (int r = 0; r < ML; r++)
          for (int j = 0; j < VL; j++)
            dp_mem[o_wraddr[AW-1 -: MAW]][r][j] <=
              dp_mem[o_wraddr[AW-1 -: MAW]][r][j] + o_a[r*XL +: XL] * o_b[j*XL +: XL];
      if (o_c_valid)
        for (int j = 0; j < VL; j++)
          dp_mem[o_wraddr[AW-1 -: MAW]][o_wraddr[RAW-1:0]][j] <= o_c[j*XL +: XL];
    end
  end

  always_comb begin
    i_dp_c = '0;
    for (int j = 0; j < VL; j++)
      i_dp_c[j*XL +: XL] = dp_mem[o_rdaddr[AW-1 -: MAW]][o_rdaddr[RAW-1:0]][j];
  end

  // ---------------- response-ready driver ----------------
  int rsp_mode = 1;  // 0: hold low, 1: hold high, 2: random
  always @(posedge clk) begin
    #1;
    case (rsp_mode)
      0:       i_rsp_ready = 1'b0;
      1:       i_rsp_ready = 1'b1;
      default: i_rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- transaction-level model ----------------
  logic [XL-1:0] m_mat [NM][ML][VL];
  int            m_clr_left;   // zero-row strobes still to appear, incl. current cycle
  int            m_clr_mreg;
  int            m_rd_stage;   // 0 none, 1 address cycle, 2 response outstanding
  logic [DW-1:0] m_rsp_data;
  logic [AW-1:0] m_rdaddr;
  bit            m_pulse;      // a single ACC/WR strobe this cycle
  bit            m_pulse_acc;
  logic [AW-1:0] m_pulse_addr;
  logic [ML*XL-1:0] m_pa;
  logic [DW-1:0] m_pb;

  function automatic bit exp_ready();
    return i_reset_n && (m_clr_left == 0) && (m_rd_stage == 0);
  endfunction

  always @(posedge clk) begin
    if (!i_reset_n) begin
      for (int m = 0; m < NM; m++)
        for (int r = 0; r < ML; r++)
          for (int j = 0; j < VL; j++) m_mat[m][r][j] <= '0;
      m_clr_left <= 0; m_clr_mreg <= 0; m_rd_stage <= 0;
      m_rsp_data <= '0; m_rdaddr <= '0; m_pulse <= 0; m_pulse_acc <= 0;
      m_pulse_addr <= '0; m_pa <= '0; m_pb <= '0;
    end else begin
      if (m_clr_left > 0) m_clr_left <= m_clr_left - 1;
      if (m_rd_stage == 1) m_rd_stage <= 2;
      else if (m_rd_stage == 2 && i_rsp_ready) m_rd_stage <= 0;
      m_pulse <= 0;
      if (i_cmd_valid && exp_ready()) begin
        case (i_cmd_op)
          OP_ACC: begin
            m_pulse <= 1; m_pulse_acc <= 1;
            m_pulse_addr <= {i_cmd_mreg, 2'b00};
            m_pa <= i_cmd_a; m_pb <= i_cmd_b;
            for (int r = 0; r < ML; r++)
              for (int j = 0; j < VL; j++)
                m_mat[i_cmd_mreg][r][j] <= m_mat[i_cmd_mreg][r][j]
                                           + i_cmd_a[r*XL +: XL] * i_cmd_b[j*XL +: XL];
          end
          OP_WR: begin
            m_pulse <= 1; m_pulse_acc <= 0;
            m_pulse_addr <= {i_cmd_mreg, i_cmd_row};
            m_pb <= i_cmd_b;
            for (int j = 0; j < VL; j++) m_mat[i_cmd_mreg][i_cmd_row][j] <= i_cmd_b[j*XL +: XL];
          end
          OP_RD: begin
            m_rd_stage <= 1;
            m_rdaddr   <= {i_cmd_mreg, i_cmd_row};
            for (int j = 0; j < VL; j++) m_rsp_data[j*XL +: XL] <= m_mat[i_cmd_mreg][i_cmd_row][j];
          end
          default: begin
            m_clr_left <= ML;
            m_clr_mreg <= int'(i_cmd_mreg);
            for (int r = 0; r < ML; r++)
              for (int j = 0; j < VL; j++) m_mat[i_cmd_mreg][r][j] <= '0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int vab_cnt = 0, cv_cnt = 0, rdy_low_cnt = 0;

  always @(negedge clk) begin
    if (o_vab_valid === 1'b1) vab_cnt <= vab_cnt + 1;
    if (o_c_valid === 1'b1)   cv_cnt  <= cv_cnt + 1;
    if (o_cmd_ready === 1'b0) rdy_low_cnt <= rdy_low_cnt + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit exp_vab = m_pulse && m_pulse_acc;
      automatic bit exp_wr  = m_pulse && !m_pulse_acc;
      automatic bit exp_clr = (m_clr_left > 0);
      check("cmd_ready", o_cmd_ready, exp_ready());
      check("idle", o_idle, !m_pulse && !exp_clr && (m_rd_stage == 0));
      check("vab_valid", o_vab_valid, exp_vab);
      check("c_valid", o_c_valid, exp_wr || exp_clr);
      check("rsp_valid", o_rsp_valid, m_rd_stage == 2);
      check("rdaddr", o_rdaddr, m_rdaddr);
      if (exp_vab) begin
        check("acc_wraddr", o_wraddr, m_pulse_addr);
        check("acc_a", o_a, m_pa);
        check("acc_b", o_b, m_pb);
      end
      if (exp_wr) begin
        check("wr_wraddr", o_wraddr, m_pulse_addr);
        check("wr_c", o_c, m_pb);
      end
      if (exp_clr) begin
        check("clr_wraddr", o_wraddr, {MAW'(m_clr_mreg), RAW'(ML - m_clr_left)});
        check("clr_c", o_c, '0);
      end
      if (m_rd_stage == 2) check("rsp_data", o_rsp_data, m_rsp_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_cmd(input opacc_op_e op, input int mreg, input int row,
                          input logic [ML*XL-1:0] a, input logic [DW-1:0] b,
                          output int waits);
    bit accepted = 0;
    waits = 0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_mreg  = MAW'(mreg);
    i_cmd_row   = RAW'(row);
    i_cmd_a     = a;
    i_cmd_b     = b;
    while (!accepted && waits < 200) begin
      @(negedge clk);
      accepted = o_cmd_ready;
      @(posedge clk);
      #1;
      if (!accepted) waits++;
    end
    check("cmd_accept", accepted, 1'b1);
    i_cmd_valid = 1'b0;
  endtask

  // RD with rsp_ready high: response two cycles after accept, literal data.
  task automatic do_rd(input int mreg, input int row, input logic [DW-1:0] exp, input string name);
    int w;
    send_cmd(OP_RD, mreg, row, '0, '0, w);
    @(negedge clk);
    check({name, "_lat1"}, o_rsp_valid, 1'b0);
    @(negedge clk);
    check({name, "_lat2"}, o_rsp_valid, 1'b1);
    check(name, o_rsp_data, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] row_of(input int e0, input int e1, input int e2, input int e3);
    return {64'(e3), 64'(e2), 64'(e1), 64'(e0)};
  endfunction

  initial begin
    int w, wsum, base, base2;
    logic [DW-1:0] ra, rb;
    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = OP_ACC;
    i_cmd_mreg = '0; i_cmd_row = '0; i_cmd_a = '0; i_cmd_b = '0; i_rsp_ready = 1'b1;

    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_ready", o_cmd_ready, 1'b0);
    check("rst_idle", o_idle, 1'b1);
    check("rst_vab", o_vab_valid, 1'b0);
    check("rst_cv", o_c_valid, 1'b0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_data", o_rsp_data, '0);
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b1;
    @(posedge clk); #1;

    // WR then RD of the same row
    send_cmd(OP_WR, 1, 2, '0, row_of(1, 2, 3, 4), w);
    do_rd(1, 2, row_of(1, 2, 3, 4), "wr_rd");

    // 4 back-to-back ACCs into mreg0
    wsum = 0;
    base = vab_cnt;
    for (int k = 0; k < 4; k++) begin
      send_cmd(OP_ACC, 0, 0, row_of(1, 1, 1, 1), row_of(2, 2, 2, 2), w);
      wsum += w;
    end
    @(negedge clk); @(posedge clk); #1;
    check("acc_b2b_stall", wsum, 0);
    check("acc_pulses", vab_cnt - base, 4);
    for (int r = 0; r < ML; r++) do_rd(0, r, row_of(8, 8, 8, 8), "acc_rd");

    // CLR mreg0
    base  = cv_cnt;
    base2 = rdy_low_cnt;
    send_cmd(OP_CLR, 0, 0, '0, '0, w);
    repeat (6) @(negedge clk);
    check("clr_pulses", cv_cnt - base, 4);
    check("clr_ready_low", rdy_low_cnt - base2, 4);
    @(posedge clk); #1;
    do_rd(0, 3, '0, "clr_rd");

    // RD stalled by rsp_ready low, WR pending meanwhile
    rsp_mode = 0;
    send_cmd(OP_RD, 1, 2, '0, '0, w);
    i_cmd_valid = 1'b1; i_cmd_op = OP_WR; i_cmd_mreg = 1'b0; i_cmd_row = 2'd1;
    i_cmd_b = row_of(5, 6, 7, 8);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", o_rsp_valid, 1'b1);
      check("stall_rsp_data", o_rsp_data, row_of(1, 2, 3, 4));
      check("stall_ready", o_cmd_ready, 1'b0);
    end
    rsp_mode = 1;
    send_cmd(OP_WR, 0, 1, '0, row_of(5, 6, 7, 8), w);
    check("stall_wr_waited", w > 0, 1'b1);
    @(posedge clk); #1;
    do_rd(0, 1, row_of(5, 6, 7, 8), "stall_wr_rd");

    // Reset on the second CLR cycle
    send_cmd(OP_WR, 0, 3, '0, row_of(9, 9, 9, 9), w);
    send_cmd(OP_CLR, 0, 0, '0, '0, w);
    @(posedge clk); #1;
    base = cv_cnt;
    i_reset_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_ready", o_cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midclr_pulses", cv_cnt - base, 1);

    // Random traffic
    rsp_mode = 2;
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 4; j++) begin
        ra[j*XL +: XL] = {$urandom, $urandom};
        rb[j*XL +: XL] = {$urandom, $urandom};
      end
      send_cmd(opacc_op_e'($urandom_range(0, 3)), int'($urandom_range(0, NM - 1)),
               int'($urandom_range(0, ML - 1)), ra, rb, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    rsp_mode = 1;
    for (int k = 0; k < 100 && o_idle !== 1'b1; k++) @(negedge clk);
    check("final_idle", o_idle, 1'b1);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
